peak_bin_reader: RTL and testbench
==================================

# peak_bin_reader

Reads the FFT result memory after a transform and locates the spectral bin with the largest magnitude, which gives the tuner its fundamental-frequency estimate. It is the read-side counterpart of the sample loader: the loader fills `mem` through its write port, and this block scans the first half of the spectrum through the same address/data port. It reports the winning bin index and magnitude, plus a valid flag and a one-cycle `done` pulse. The port owner selects between loader and reader addresses using `mem_re`.

## Interface
Parameters:
- `ADDR_W`, 11: width of the memory address.
- `DATA_W`, 10: width of a magnitude word, unsigned.
- `N_BINS`, 1024: bins scanned, covering addresses 0..N_BINS-1 (the lower half of a 2048-point spectrum).
- `MIN_MAG`, 16: minimum peak magnitude for `peak_valid` to assert.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: starts a scan; sampled only in IDLE.
- `mem_addr`  out  ADDR_W: read address into `mem`.
- `mem_re`  out  1: high while this block owns the memory address port.
- `mem_data`  in  DATA_W: memory read data, returned one cycle after the address.
- `busy`  out  1: high in SCAN, DRAIN and DONE.
- `done`  out  1: one-cycle pulse when the result is updated.
- `peak_bin`  out  ADDR_W: index of the maximum bin.
- `peak_mag`  out  DATA_W: magnitude of the maximum bin.
- `peak_valid`  out  1: `peak_mag >= MIN_MAG`.

## Operation
- The state machine has four states: IDLE, SCAN, DRAIN and DONE.
- IDLE:
  - `start`=1 latches S into `mem_addr`. S is the first bin: 0, or 1 with the DC-skip macro.
  - The running maximum is cleared to 0 and the running bin is set to S.
  - The next state is SCAN.
- SCAN:
  - `mem_re`=1, and `mem_addr` increments by 1 every cycle.
  - A delayed-valid flag marks when `mem_data` corresponds to the address presented one cycle earlier.
  - When that flag is set, the returned magnitude is compared against the running maximum.
  - When `mem_addr` = N_BINS-1, the next state is DRAIN.
- DRAIN:
  - `mem_re`=0, and the final data word is compared.
  - The next state is DONE.
- DONE:
  - `peak_bin`, `peak_mag` and `peak_valid` load from the running registers, and `done`=1 for this cycle only.
  - The next state is IDLE.
- Comparison rule:
  - The running maximum is replaced only on a strictly greater value, so on ties the lowest bin index wins.
  - If every magnitude is 0, the result is `peak_bin`=S and `peak_mag`=0.
- Magnitudes are treated as unsigned DATA_W values; no widening or scaling is applied.
- Outputs hold the last result until the next DONE and are not disturbed by a new scan in progress.
- `start` while `busy`=1 is ignored; there is no queueing.
- `mem_addr` is 0 whenever `mem_re`=0.

## Timing
- Reset values: state IDLE; `mem_addr`=0, `mem_re`=0, `busy`=0, `done`=0, `peak_bin`=0, `peak_mag`=0, `peak_valid`=0.
- Scan timing, with `start` sampled at edge T and N = N_BINS - S:
  - `mem_addr`=S+k during the cycle after edge T+k, for k = 0..N-1.
  - The last address is presented after edge T+N-1.
  - DRAIN occupies the cycle after edge T+N.
  - `done`=1 in the cycle after edge T+N+1.
  - The block is back in IDLE after edge T+N+2.
- Latency from the `start` edge to `done` high:
  - N_BINS+1 = 1025 cycles without the DC-skip macro.
  - 1024 cycles with it.
- `mem_re` rises with the first address and falls after the last address cycle.
- Memory read latency is exactly 1 cycle; no other latency is supported.
- Reset mid-scan:
  - All outputs return to their reset values immediately.
  - The partial result is discarded.
  - A `start` after reset release begins a fresh scan.
- `start` may be held high. After DONE→IDLE, a still-high `start` begins another scan one cycle later.

## Configuration
- `PEAK_SKIP_DC_EN` defined:
  - The scan starts at bin 1 (S=1), and bin 0 is never read or compared.
  - An all-zero spectrum reports `peak_bin`=1.
- `PEAK_SKIP_DC_EN` undefined:
  - The scan starts at bin 0 (S=0).
  - The DC bin is a candidate like any other.

## Test plan
- Single peak, macro off: memory holds 5 in every bin except bin 300 = 700; pulse `start` → `peak_bin`=300, `peak_mag`=700, `peak_valid`=1, `done` high exactly 1025 cycles after the start edge, for one cycle.
- Tie: bins 100 and 200 = 900, all others 3 → `peak_bin`=100, `peak_mag`=900.
- DC handling: bin 0 = 1023, bin 50 = 400, others 0:
  - macro off → `peak_bin`=0, `peak_mag`=1023;
  - macro on → `peak_bin`=50, `peak_mag`=400, `done` after 1024 cycles.
- Threshold and boundary:
  - all bins ≤ 10, bin 1023 = 12, `MIN_MAG`=16 → `peak_bin`=1023, `peak_mag`=12, `peak_valid`=0;
  - check `mem_addr` never exceeds 1023.
- Reset mid-scan: assert `rst` while `mem_addr`=500 → same cycle `busy`=0, `mem_re`=0, `mem_addr`=0, `peak_*`=0; a following `start` produces the correct result with full latency.
- Busy protection: pulse `start` again at `mem_addr`=10 → no restart, `done` pulses once at the original time, and the result is unchanged from a single-start run.

Source files
------------

// File: rtl/peak_bin_reader.sv
// -----------------------------------------------------------------------------
// peak_bin_reader
//
// Scans the lower half of the FFT result memory after a transform and reports
// the bin with the largest (unsigned) magnitude. It shares the memory
// address/data port with the sample loader; mem_re tells the port owner that
// this block is currently driving the address.
//
// Optional feature (compile-time macro):
//   PEAK_SKIP_DC_EN  - when defined, the scan starts at bin 1 so the DC bin is
//                      never read or compared. When undefined, bin 0 is a
//                      candidate like any other bin.
//
// Parameters:
//   ADDR_W   memory address width
//   DATA_W   magnitude word width (unsigned)
//   N_BINS   number of bins scanned, addresses 0..N_BINS-1
//   MIN_MAG  minimum peak magnitude for peak_valid
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a scan (sampled only in IDLE)
//   mem_addr   out  read address into the result memory (0 when mem_re=0)
//   mem_re     out  high while this block owns the memory address port
//   mem_data   in   read data, valid one cycle after its address
//   busy       out  high in SCAN, DRAIN and DONE
//   done       out  one-cycle pulse when the peak outputs are updated
//   peak_bin   out  index of the maximum bin
//   peak_mag   out  magnitude of the maximum bin
//   peak_valid out  peak_mag >= MIN_MAG
//   fsm_state  out  current FSM state encoding (debug visibility)
//
// Handshake: start is a level sampled only while busy=0; a sampled start
// commits the block to exactly one scan, which ends with a single done pulse.
// start seen while busy=1 is dropped (no queueing). The memory side is a
// fixed-latency read: an address presented in cycle c returns data in c+1;
// there is no back-pressure on either side.
// -----------------------------------------------------------------------------
module peak_bin_reader #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 10,
  parameter int N_BINS  = 1024,
  parameter int MIN_MAG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              peak_valid,
  output logic [1:0]        fsm_state
);

`ifdef PEAK_SKIP_DC_EN
  localparam int FIRST_BIN = 1;
`else
  localparam int FIRST_BIN = 0;
`endif

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIRST_BIN);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_BINS - 1);
  localparam logic [DATA_W-1:0] MIN_MAG_W  = DATA_W'(MIN_MAG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Tag for the word currently on mem_data: rd_valid says it belongs to an
  // address this block issued last cycle, rd_bin says which one.
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_bin;

  // Running maximum for the scan in progress.
  logic [DATA_W-1:0] run_max;
  logic [ADDR_W-1:0] run_bin;

  // Strictly-greater replacement keeps the lowest index on ties.
  logic              take;
  logic [DATA_W-1:0] cand_max;
  logic [ADDR_W-1:0] cand_bin;

  assign take     = rd_valid && (mem_data > run_max);
  assign cand_max = take ? mem_data : run_max;
  assign cand_bin = take ? rd_bin   : run_bin;

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    mem_re     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        mem_re = 1'b1;
        if (mem_addr == LAST_ADDR) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Last data word is on mem_data this cycle; it is folded in at the
        // edge that leaves DRAIN.
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generator: registered so mem_addr is clean and is forced to 0
  // outside SCAN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= START_ADDR;
          end else begin
            mem_addr <= '0;
          end
        end
        SCAN: begin
          if (mem_addr == LAST_ADDR) begin
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: begin
          mem_addr <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data tag pipeline (matches the one-cycle memory latency)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_bin   <= '0;
    end else begin
      rd_valid <= mem_re;
      rd_bin   <= mem_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Running maximum
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max <= '0;
      run_bin <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        run_max <= '0;
        run_bin <= START_ADDR;
      end
    end else if (take) begin
      run_max <= mem_data;
      run_bin <= rd_bin;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded on the DRAIN->DONE edge from the candidate values
  // so the final word compared in DRAIN is included, and so the result is
  // already visible while done is high. Untouched at any other time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else if (state == DRAIN) begin
      peak_bin   <= cand_bin;
      peak_mag   <= cand_max;
      peak_valid <= (cand_max >= MIN_MAG_W);
    end
  end

endmodule

// File: tb/tb_peak_bin_reader.sv
// -----------------------------------------------------------------------------
// tb_peak_bin_reader
//
// Directed testbench for peak_bin_reader. Holds a behavioural model of the
// FFT result memory (one-cycle read latency), loads hand-built spectra and
// compares the reported peak, timing and address sequence against values
// worked out by hand for each spectrum.
// -----------------------------------------------------------------------------
module tb_peak_bin_reader;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 10;
  localparam int N_BINS  = 1024;
  localparam int MIN_MAG = 16;

`ifdef PEAK_SKIP_DC_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam int NB  = N_BINS - S;  // addresses read per scan
  localparam int LAT = NB + 1;      // start edge to done high, in cycles

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] peak_bin;
  logic [DATA_W-1:0] peak_mag;
  logic              peak_valid;
  logic [1:0]        fsm_state;

  int vectors;
  int miscompares;

  logic [DATA_W-1:0] mem [0:2047];

  peak_bin_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_BINS (N_BINS),
    .MIN_MAG(MIN_MAG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .peak_valid(peak_valid),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and memory model
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    mem_data <= mem[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic fill_all(input logic [DATA_W-1:0] v);
    for (int i = 0; i < 2048; i++) mem[i] = v;
  endtask

  // Starts a scan and watches it cycle by cycle. k counts cycles after the
  // start edge (k=0 is the cycle right after it). restart_k pulses start
  // again during cycle k; hold keeps start high throughout.
  task automatic run_scan(input int restart_k, input bit hold,
                          output int lat, output int n_done,
                          output bit addr_ok, output int max_addr);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    lat      = -1;
    n_done   = 0;
    addr_ok  = 1'b1;
    max_addr = 0;
    for (int k = 0; k < 1200; k++) begin
      if (k > 0) @(negedge clk);
      if (!hold) start = (k == restart_k);
      if (mem_re && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      if (k < NB) begin
        if (!mem_re || int'(mem_addr) != S + k) addr_ok = 1'b0;
      end else if (k < NB + 3) begin
        if (mem_re || mem_addr != '0) addr_ok = 1'b0;
      end
      if (done) begin
        n_done++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    fill_all('0);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, mem_re, done, peak_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: busy/mem_re/done/valid=%b expected 0000", {busy, mem_re, done, peak_valid});
    end
    vectors++;
    if (mem_addr !== '0 || peak_bin !== '0 || peak_mag !== '0) begin
      miscompares++;
      $display("FAIL reset_values: addr=%0d bin=%0d mag=%0d expected 0 0 0", mem_addr, peak_bin, peak_mag);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b state=%0d expected 0 0", busy, fsm_state);
    end
  endtask

  task automatic test_single_peak();
    int lat, n_done, max_addr;
    bit addr_ok;
    fill_all(10'd5);
    mem[300] = 10'd700;
    run_scan(-1, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
    if (peak_bin !== 11'd300 || peak_mag !== 10'd700 || peak_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_peak: bin=%0d mag=%0d valid=%b expected 300 700 1", peak_bin, peak_mag, peak_valid);
    end
    vectors++;
    if (lat !== LAT || n_done !== 1) begin
      miscompares++;
      $display("FAIL single_latency: lat=%0d pulses=%0d expected %0d 1", lat, n_done, LAT);
    end
    vectors++;
    if (addr_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL addr_sequence: got bad sequence expected S..N_BINS-1 then 0");
    end
  endtask

  task automatic test_tie();
    int lat, n_done, max_addr;
    bit addr_ok;
    fill_all(10'd3);
    mem[100] = 10'd900;
    mem[200] = 10'd900;
    run_scan(-1, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
    if (peak_bin !== 11'd100 || peak_mag !== 10'd900) begin
      miscompares++;
      $display("FAIL tie: bin=%0d mag=%0d expected 100 900", peak_bin, peak_mag);
    end
  endtask

  task automatic test_dc();
    int lat, n_done, max_addr;
    bit addr_ok;
    fill_all('0);
    mem[0]  = 10'd1023;
    mem[50] = 10'd400;
    run_scan(-1, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
`ifdef PEAK_SKIP_DC_EN
    if (peak_bin !== 11'd50 || peak_mag !== 10'd400) begin
      miscompares++;
      $display("FAIL dc_skip: bin=%0d mag=%0d expected 50 400", peak_bin, peak_mag);
    end
`else
    if (peak_bin !== 11'd0 || peak_mag !== 10'd1023) begin
      miscompares++;
      $display("FAIL dc_bin: bin=%0d mag=%0d expected 0 1023", peak_bin, peak_mag);
    end
`endif
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL dc_latency: lat=%0d expected %0d", lat, LAT);
    end
  endtask

  task automatic test_all_zero();
    int lat, n_done, max_addr;
    bit addr_ok;
    fill_all('0);
    run_scan(-1, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
    if (int'(peak_bin) !== S || peak_mag !== '0 || peak_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL all_zero: bin=%0d mag=%0d valid=%b expected %0d 0 0", peak_bin, peak_mag, peak_valid, S);
    end
  endtask

  task automatic test_threshold();
    int lat, n_done, max_addr;
    bit addr_ok;
    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i % 11);
    // Big values beyond the scan window catch any over-read.
    for (int i = 1024; i < 2048; i++) mem[i] = 10'd1000;
    mem[1023] = 10'd12;
    run_scan(-1, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
    if (peak_bin !== 11'd1023 || peak_mag !== 10'd12 || peak_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL threshold: bin=%0d mag=%0d valid=%b expected 1023 12 0", peak_bin, peak_mag, peak_valid);
    end
    vectors++;
    if (max_addr !== 1023) begin
      miscompares++;
      $display("FAIL max_addr: got %0d expected 1023", max_addr);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, n_done, max_addr;
    bit addr_ok;
    bit found;
    fill_all(10'd5);
    mem[300] = 10'd700;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (mem_addr == 11'd500) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_addr_500: got not reached expected reached");
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, mem_re, done, peak_valid} !== 4'b0000 || mem_addr !== '0) begin
      miscompares++;
      $display("FAIL midscan_reset_ctrl: flags=%b addr=%0d expected 0000 0", {busy, mem_re, done, peak_valid}, mem_addr);
    end
    vectors++;
    if (peak_bin !== '0 || peak_mag !== '0) begin
      miscompares++;
      $display("FAIL midscan_reset_peak: bin=%0d mag=%0d expected 0 0", peak_bin, peak_mag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan(-1, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
    if (peak_bin !== 11'd300 || peak_mag !== 10'd700 || lat !== LAT) begin
      miscompares++;
      $display("FAIL after_reset_scan: bin=%0d mag=%0d lat=%0d expected 300 700 %0d", peak_bin, peak_mag, lat, LAT);
    end
  endtask

  task automatic test_busy_protect();
    int lat, n_done, max_addr;
    bit addr_ok;
    fill_all(10'd5);
    mem[300] = 10'd700;
    mem[7]   = 10'd650;
    run_scan(10 - S, 1'b0, lat, n_done, addr_ok, max_addr);
    vectors++;
    if (lat !== LAT || n_done !== 1 || addr_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_restart: lat=%0d pulses=%0d addr_ok=%b expected %0d 1 1", lat, n_done, addr_ok, LAT);
    end
    vectors++;
    if (peak_bin !== 11'd300 || peak_mag !== 10'd700) begin
      miscompares++;
      $display("FAIL busy_result: bin=%0d mag=%0d expected 300 700", peak_bin, peak_mag);
    end
  endtask

  task automatic test_start_held();
    int lat, n_done, max_addr;
    bit addr_ok;
    bit got_done;
    fill_all(10'd2);
    mem[600] = 10'd64;
    run_scan(-1, 1'b1, lat, n_done, addr_ok, max_addr);
    // run_scan returns in the cycle where the follow-on scan has started.
    vectors++;
    if (lat !== LAT || mem_re !== 1'b1 || int'(mem_addr) !== S) begin
      miscompares++;
      $display("FAIL held_restart: lat=%0d mem_re=%b addr=%0d expected %0d 1 %0d", lat, mem_re, mem_addr, LAT, S);
    end
    mem[800] = 10'd80;
    got_done = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    vectors++;
    if (got_done !== 1'b1 || peak_bin !== 11'd800 || peak_mag !== 10'd80 || peak_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL held_second: done=%b bin=%0d mag=%0d valid=%b expected 1 800 80 1", got_done, peak_bin, peak_mag, peak_valid);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    test_reset();
    test_single_peak();
    test_tie();
    test_dc();
    test_all_zero();
    test_threshold();
    test_reset_mid_scan();
    test_busy_protect();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
